// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

  // One buffered fetch result: instruction word tagged with its PC.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/flush and registered count/full/empty.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count_nxt;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // A push into a full FIFO is accepted only when a pop frees the slot.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + CW'(1);
    else if (do_pop && !do_push) count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: sequential PC generation, credit-limited imem
// requests, in-order response buffering and branch redirect with drop tracking.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = ((OW > FW) ? OW : FW) + 1;

  logic [XLEN-1:0] pc;
  logic [OW-1:0]   drop_count, pcq_count, outstanding;
  logic [FW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty, pcq_full, pcq_empty;
  logic [XLEN-1:0] pcq_head;
  logic            credit_ok, req_fire, resp_keep, resp_drop, instr_pop;
  fetch_entry_t    push_entry, head;

  // Live requests sit in the PC queue; wrong-path ones are only counted.
  assign outstanding = pcq_count + drop_count;

  assign credit_ok = ((SW'(outstanding) + SW'(fifo_count)) < SW'(FIFO_DEPTH))
                   && (outstanding < OW'(MAX_OUTSTANDING))
                   && !fifo_full && !pcq_full;

  assign imem_req_valid = !rst && !branch_taken && credit_ok;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_drop = imem_resp_valid && (drop_count != '0);
  assign resp_keep = imem_resp_valid && (drop_count == '0) && !pcq_empty;

  assign instr_valid = !rst && !branch_taken && !fifo_empty;
  assign instr_pop   = instr_valid && instr_ready;
  assign instr       = instr_valid ? head.instr : NOP_INSTR;
  assign instr_pc    = head.pc;

  assign push_entry = '{pc: pcq_head, instr: imem_resp_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      drop_count <= '0;
    end else if (branch_taken) begin
      pc         <= align_pc(branch_addr);
      drop_count <= outstanding - OW'(imem_resp_valid);
    end else begin
      if (req_fire)  pc         <= pc + XLEN'(INSTR_BYTES);
      if (resp_drop) drop_count <= drop_count - OW'(1);
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_taken),
    .push      (resp_keep),
    .push_data (push_entry),
    .pop       (instr_pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_taken),
    .push      (req_fire),
    .push_data (pc),
    .pop       (resp_keep),
    .pop_data  (pcq_head),
    .count     (pcq_count),
    .full      (pcq_full),
    .empty     (pcq_empty)
  );

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage at the head of the pipeline. Generates sequential PCs and issues requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions in a small in-order FIFO and presents them with their PC to decode.
- Redirects to the branch stage's registered target whenever branch_taken is high, discarding every wrong-path request and response.
- Consumes branch_taken/branch_addr directly from the branch stage; the instr_pc it delivers ultimately becomes that stage's branch base.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2).
- MAX_OUTSTANDING, 2, maximum issued-but-unanswered imem requests.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- branch_taken  in  1  redirect request; registered output of branch stage.
- branch_addr  in  32  redirect target; valid when branch_taken=1.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_resp_valid  in  1  response data valid; in-order; cannot be back-pressured.
- imem_resp_data  in  32  instruction word.
- instr_valid  out  1  instr/instr_pc valid to decode.
- instr_ready  in  1  decode accepts instruction.
- instr  out  32  instruction word.
- instr_pc  out  32  PC of instr.

Behaviour:
- Reset:
  - rst high at a rising edge sets pc=RESET_PC, FIFO empty, outstanding=0, drop_count=0.
  - Outputs during reset: imem_req_valid=0, instr_valid=0.
  - First request issues in the cycle after rst deasserts.
  - Reset mid-operation abandons all in-flight traffic. Responses arriving after reset are NOT tracked; the memory side must also be reset.
- Request rules:
  - imem_req_valid=1 iff !rst && !branch_taken && (outstanding + fifo_count) < FIFO_DEPTH && outstanding < MAX_OUTSTANDING.
  - The credit check guarantees every response has a FIFO slot.
  - imem_req_addr = pc.
  - On req fire (valid && ready): pc <= pc+4, outstanding++. pc wraps modulo 2^32.
  - valid, once asserted, holds with a stable address until fire or redirect.
- Response rules:
  - On imem_resp_valid: outstanding--.
  - If drop_count>0, the response is discarded and drop_count decrements.
  - Otherwise {data, pc_of_request} is pushed into the FIFO; the request PC is carried in a parallel PC queue of depth MAX_OUTSTANDING.
  - Simultaneous fire and response: outstanding unchanged.
- Output rules:
  - instr_valid = FIFO not empty and no redirect this cycle.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle with FIFO full or empty is legal. Full+pop+push keeps count; empty pass-through takes 1 cycle, with no combinational resp→instr path.
- Redirect (branch_taken=1 at a rising edge):
  - pc <= {branch_addr[31:2], 2'b00}.
  - FIFO and PC queue flushed; drop_count <= outstanding minus (imem_resp_valid ? 1 : 0), counted before this cycle's decrement.
  - imem_req_valid and instr_valid forced 0 during the redirect cycle, so no fire and no pop can occur.
  - Fetching resumes from the new pc the next cycle.
  - A redirect during a non-zero drop_count accumulates: drop_count <= drop_count + outstanding_not_yet_counted.
  - Back-to-back redirects: the last one wins.
- Latency: redirect → first request 1 cycle; request fire → instr_valid = memory latency + 1 cycle.
- Invariants: outstanding ≤ MAX_OUTSTANDING; fifo_count + outstanding − drop_count ≤ FIFO_DEPTH; drop_count ≤ outstanding.

Decomposition:
- Shared package: XLEN=32, RESET_PC default, INSTR_BYTES=4, and the NOP encoding 32'h0000_0013 (decode's bubble value).
- One natural sub-module: fetch_fifo, a synchronous FIFO with push/pop/flush, count, and full/empty.
  - Instantiated twice: the instruction FIFO, and the PC queue at width 32.

Test Plan:
- Reset release, memory with 1-cycle latency, instr_ready=1 → requests at 0x0,0x4,0x8…; instr_valid first high 2 cycles after first fire; instr_pc sequence 0x0,0x4,0x8.
- instr_ready=0 for 10 cycles → exactly FIFO_DEPTH=2 requests issued, imem_req_valid=0 thereafter; raising instr_ready delivers 0x0,0x4 in order with none lost.
- Redirect with 2 outstanding, branch_addr=0x100 → both stale responses dropped; next instr_pc=0x100; imem_req_addr=0x100 one cycle after branch_taken.
- branch_taken coincident with imem_resp_valid and 1 further outstanding → drop_count=1; neither old word reaches decode.
- branch_addr=0x203 → fetch at 0x200; pc=0xFFFF_FFFC sequential → next request 0x0000_0000.
- rst asserted mid-stream with FIFO full → the next cycle instr_valid=0 and imem_req_valid=0; after release, fetch restarts at RESET_PC.
